// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for the single-port data RAM: the CPU has priority, the display is
// served after MAX_WAIT denials. Optional perf counters are enabled by the ARB_PERF_CNT_EN macro.
module dmem_port_arbiter #(
    parameter int DATA_W   = 18,
    parameter int ADDR_W   = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [15:0]       perf_stall_cnt,
    output logic [15:0]       perf_force_cnt
`endif
);

    localparam logic [1:0] RET_NONE = 2'd0;
    localparam logic [1:0] RET_CPU  = 2'd1;
    localparam logic [1:0] RET_DISP = 2'd2;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic [3:0] wait_cnt_reg, wait_cnt_next;
    logic [1:0] ret_state_reg, ret_state_next;
    logic       force_disp;
    logic       disp_win;
    logic       cpu_gnt;

    always_comb begin
        force_disp = disp_req & (wait_cnt_reg == MAX_WAIT_C);
        disp_win   = force_disp | (disp_req & ~cpu_req);
        cpu_gnt    = cpu_req & ~disp_win;
    end

    assign cpu_stall = cpu_req & ~cpu_gnt;
    assign disp_gnt  = disp_req & disp_win;

    // Display accesses are always reads; everything drops to zero when nobody is granted.
    always_comb begin
        mem_en    = cpu_gnt | disp_gnt;
        mem_we    = cpu_gnt & cpu_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_addr = cpu_addr;
            if (cpu_we) begin
                mem_wdata = cpu_wdata;
            end
        end else if (disp_gnt) begin
            mem_addr = disp_addr;
        end
    end

    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (!disp_req || disp_gnt) begin
            wait_cnt_next = 4'd0;
        end else if (wait_cnt_reg < MAX_WAIT_C) begin
            wait_cnt_next = wait_cnt_reg + 4'd1;
        end
    end

    always_comb begin
        ret_state_next = RET_NONE;
        if (cpu_gnt && !cpu_we) begin
            ret_state_next = RET_CPU;
        end else if (disp_gnt) begin
            ret_state_next = RET_DISP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_reg  <= 4'd0;
            ret_state_reg <= RET_NONE;
        end else begin
            wait_cnt_reg  <= wait_cnt_next;
            ret_state_reg <= ret_state_next;
        end
    end

    // Gating with rst drops a read whose return cycle coincides with reset.
    assign cpu_rvalid  = (ret_state_reg == RET_CPU) & ~rst;
    assign disp_rvalid = (ret_state_reg == RET_DISP) & ~rst;
    assign cpu_rdata   = cpu_rvalid ? mem_rdata : '0;
    assign disp_rdata  = disp_rvalid ? mem_rdata : '0;

`ifdef ARB_PERF_CNT_EN
    logic [1:0]  perf_inc;
    logic [15:0] perf_cnt_reg [2];

    assign perf_inc[0] = cpu_stall;
    assign perf_inc[1] = force_disp;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_perf
            always_ff @(posedge clk) begin
                if (rst) begin
                    perf_cnt_reg[gi] <= 16'd0;
                end else if (perf_inc[gi] && perf_cnt_reg[gi] != 16'hFFFF) begin
                    perf_cnt_reg[gi] <= perf_cnt_reg[gi] + 16'd1;
                end
            end
        end
    endgenerate

    assign perf_stall_cnt = perf_cnt_reg[0];
    assign perf_force_cnt = perf_cnt_reg[1];
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Table-driven bench for dmem_port_arbiter with a behavioural RAM and a read-return scoreboard.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_addr;
    logic [17:0] cpu_wdata;
    logic        cpu_stall, cpu_rvalid;
    logic [17:0] cpu_rdata;
    logic        disp_req;
    logic [15:0] disp_addr;
    logic        disp_gnt, disp_rvalid;
    logic [17:0] disp_rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr;
    logic [17:0] mem_wdata;
    logic [17:0] mem_rdata;
`ifdef ARB_PERF_CNT_EN
    logic [15:0] perf_stall_cnt, perf_force_cnt;
`endif

    always #5 clk = ~clk;

    dmem_port_arbiter #(.DATA_W(18), .ADDR_W(16), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
        .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
`ifdef ARB_PERF_CNT_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_force_cnt(perf_force_cnt)
`endif
    );

    logic [17:0] ram    [0:65535];
    logic [17:0] shadow [0:65535];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    typedef struct {
        logic        rst, creq, cwe;
        logic [15:0] caddr;
        logic [17:0] cwdata;
        logic        dreq;
        logic [15:0] daddr;
        logic        e_stall, e_gnt, e_en, e_we;
        logic [15:0] e_addr;
        logic [17:0] e_wdata;
    } vec_t;

    typedef struct {
        logic        cv;
        logic [17:0] cd;
        logic        dv;
        logic [17:0] dd;
    } ret_t;

    vec_t vecs[$];
    ret_t sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic add(input logic r, input logic creq, input logic cwe, input logic [15:0] caddr,
                       input logic [17:0] cwdata, input logic dreq, input logic [15:0] daddr,
                       input logic e_stall, input logic e_gnt, input logic e_en, input logic e_we,
                       input logic [15:0] e_addr, input logic [17:0] e_wdata);
        vec_t v;
        v = '{r, creq, cwe, caddr, cwdata, dreq, daddr, e_stall, e_gnt, e_en, e_we, e_addr, e_wdata};
        vecs.push_back(v);
    endtask

    task automatic idle(input logic r);
        add(r, 0, 0, 16'h0, 18'h0, 0, 16'h0, 0, 0, 0, 0, 16'h0, 18'h0);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d got=%h want=%h", name, idx, act, exp);
        end
    endtask

    initial begin
        ret_t r;
        vec_t v;

        for (int a = 0; a < 65536; a++) begin
            ram[a]    = 18'h0;
            shadow[a] = 18'h0;
        end
        ram[16'h0010] = 18'h2A5A5;  shadow[16'h0010] = 18'h2A5A5;
        ram[16'h0100] = 18'h1B00F;  shadow[16'h0100] = 18'h1B00F;
        ram[16'h0200] = 18'h0ABCD;  shadow[16'h0200] = 18'h0ABCD;

        // reset: combinational paths follow inputs, no read returns
        idle(1);
        add(1, 1, 0, 16'h0010, 0, 0, 0,          0, 0, 1, 0, 16'h0010, 0);
        idle(0);
        // CPU-only load, DISP-only read, store then load back
        add(0, 1, 0, 16'h0010, 0, 0, 0,          0, 0, 1, 0, 16'h0010, 0);
        idle(0);
        add(0, 0, 0, 16'h0, 0, 1, 16'h0100,      0, 1, 1, 0, 16'h0100, 0);
        idle(0);
        add(0, 1, 1, 16'h0030, 18'h12345, 0, 0,  0, 0, 1, 1, 16'h0030, 18'h12345);
        add(0, 1, 0, 16'h0030, 0, 0, 0,          0, 0, 1, 0, 16'h0030, 0);
        idle(0);
        // contention: 4 CPU grants then one forced DISP grant, repeating
        for (int k = 0; k < 10; k++) begin
            if (k % 5 == 4) add(0, 1, 0, 16'h0040, 0, 1, 16'h0200, 1, 1, 1, 0, 16'h0200, 0);
            else            add(0, 1, 0, 16'h0040, 0, 1, 16'h0200, 0, 0, 1, 0, 16'h0040, 0);
        end
        idle(0);
        // same-address collision: forced DISP read sees the pre-store value
        for (int k = 0; k < 4; k++) add(0, 1, 0, 16'h0050, 0, 1, 16'h0020, 0, 0, 1, 0, 16'h0050, 0);
        add(0, 1, 1, 16'h0020, 18'h3FFFF, 1, 16'h0020, 1, 1, 1, 0, 16'h0020, 0);
        add(0, 1, 1, 16'h0020, 18'h3FFFF, 0, 0,        0, 0, 1, 1, 16'h0020, 18'h3FFFF);
        add(0, 1, 0, 16'h0020, 0, 0, 0,                0, 0, 1, 0, 16'h0020, 0);
        idle(0);
        // reset in the return cycle of a DISP read
        add(0, 0, 0, 16'h0, 0, 1, 16'h0100,      0, 1, 1, 0, 16'h0100, 0);
        idle(1);
        idle(0);
        // reset clears a partially built wait count
        add(0, 1, 0, 16'h0040, 0, 1, 16'h0200,   0, 0, 1, 0, 16'h0040, 0);
        add(0, 1, 0, 16'h0040, 0, 1, 16'h0200,   0, 0, 1, 0, 16'h0040, 0);
        add(1, 1, 0, 16'h0040, 0, 1, 16'h0200,   0, 0, 1, 0, 16'h0040, 0);
        for (int k = 0; k < 4; k++) add(0, 1, 0, 16'h0040, 0, 1, 16'h0200, 0, 0, 1, 0, 16'h0040, 0);
        add(0, 1, 0, 16'h0040, 0, 1, 16'h0200,   1, 1, 1, 0, 16'h0200, 0);
        idle(0);
        idle(0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            v = vecs[i];
            rst = v.rst; cpu_req = v.creq; cpu_we = v.cwe; cpu_addr = v.caddr; cpu_wdata = v.cwdata;
            disp_req = v.dreq; disp_addr = v.daddr;
            #1;
            r = '{1'b0, 18'h0, 1'b0, 18'h0};
            if (sb.size() > 0) r = sb.pop_front();
            if (v.rst) r = '{1'b0, 18'h0, 1'b0, 18'h0};
            chk("cpu_rvalid", i, 32'(cpu_rvalid), 32'(r.cv));
            chk("cpu_rdata", i, 32'(cpu_rdata), 32'(r.cd));
            chk("disp_rvalid", i, 32'(disp_rvalid), 32'(r.dv));
            chk("disp_rdata", i, 32'(disp_rdata), 32'(r.dd));
            chk("cpu_stall", i, 32'(cpu_stall), 32'(v.e_stall));
            chk("disp_gnt", i, 32'(disp_gnt), 32'(v.e_gnt));
            chk("mem_en", i, 32'(mem_en), 32'(v.e_en));
            chk("mem_we", i, 32'(mem_we), 32'(v.e_we));
            chk("mem_addr", i, 32'(mem_addr), 32'(v.e_addr));
            chk("mem_wdata", i, 32'(mem_wdata), 32'(v.e_wdata));
            r = '{1'b0, 18'h0, 1'b0, 18'h0};
            if (!v.rst) begin
                if (v.e_gnt) begin
                    r.dv = 1'b1; r.dd = shadow[v.daddr];
                end else if (v.e_en && !v.e_we) begin
                    r.cv = 1'b1; r.cd = shadow[v.e_addr];
                end
            end
            if (v.e_en && v.e_we) shadow[v.e_addr] = v.e_wdata;
            sb.push_back(r);
            $display("vec %0d rst=%0b cpu=%0b/%0b@%h disp=%0b@%h -> stall=%0b gnt=%0b mem=%0b/%0b@%h crv=%0b %h drv=%0b %h",
                     i, v.rst, v.creq, v.cwe, v.caddr, v.dreq, v.daddr, cpu_stall, disp_gnt,
                     mem_en, mem_we, mem_addr, cpu_rvalid, cpu_rdata, disp_rvalid, disp_rdata);
        end

`ifdef ARB_PERF_CNT_EN
        @(posedge clk); #1;
        rst = 1; cpu_req = 0; cpu_we = 0; disp_req = 0;
        @(posedge clk); #1;
        rst = 0; cpu_req = 1; cpu_addr = 16'h0040; disp_req = 1; disp_addr = 16'h0200;
        repeat (50) @(posedge clk);
        #1;
        cpu_req = 0; disp_req = 0;
        chk("perf_stall_cnt", 0, 32'(perf_stall_cnt), 32'd10);
        chk("perf_force_cnt", 0, 32'(perf_force_cnt), 32'd10);
        $display("perf stall=%0d force=%0d", perf_stall_cnt, perf_force_cnt);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
